data_mem_arbiter: RTL

//  Round-robin arbiter directly upstream of Data_memory; shares its single port among the 8 cores.

---
 rtl/data_mem_arbiter_if.sv | 31 +++
 rtl/data_mem_arbiter.sv | 116 +++++++++++
 2 files changed

// File: rtl/data_mem_arbiter_if.sv
// Core-side request/grant bus and Data_memory command bus shared by data_mem_arbiter.
// Handshake: a core holds core_req (with core_we/addr/wdata stable) until it samples core_gnt=1 at a
// rising edge; that edge is the transfer. Reads complete later with a one-cycle core_rvalid strobe.
interface data_mem_arbiter_if #(
  parameter int NUM_CORES = 8,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16
);
  logic [NUM_CORES-1:0]        core_req;
  logic [NUM_CORES-1:0]        core_we;
  logic [NUM_CORES*ADDR_W-1:0] core_addr;
  logic [NUM_CORES*DATA_W-1:0] core_wdata;
  logic [NUM_CORES-1:0]        core_gnt;
  logic [NUM_CORES-1:0]        core_rvalid;
  logic [DATA_W-1:0]           core_rdata;
  logic                        mem_read;
  logic                        mem_write;
  logic [ADDR_W-1:0]           mem_address;
  logic [DATA_W-1:0]           mem_data_in;
  logic [DATA_W-1:0]           mem_data_out;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata, mem_data_out,
    output core_gnt, core_rvalid, core_rdata, mem_read, mem_write, mem_address, mem_data_in
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata, mem_data_out,
    input  core_gnt, core_rvalid, core_rdata, mem_read, mem_write, mem_address, mem_data_in
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing the single Data_memory port among NUM_CORES cores.
// Optional MEM_ARB_STATS_EN adds saturating per-core grant counters and a conflict counter.
module data_mem_arbiter #(
  parameter int NUM_CORES = 8,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int RD_LAT    = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  data_mem_arbiter_if.slave            bus,
  output logic [$clog2(NUM_CORES)-1:0] dbg_rr_ptr
`ifdef MEM_ARB_STATS_EN
  ,
  input  logic [$clog2(NUM_CORES)-1:0] stat_sel,
  output logic [15:0]                  stat_count,
  output logic [15:0]                  stat_conflict
`endif
);
  localparam int ID_W = $clog2(NUM_CORES);

  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      winner;
  logic [ID_W-1:0]      idx;
  logic                 found;
  logic                 win_we;

  logic                 mem_read_q;
  logic                 mem_write_q;
  logic [ADDR_W-1:0]    mem_address_q;
  logic [DATA_W-1:0]    mem_data_in_q;
  logic [NUM_CORES-1:0] rvalid_q;
  logic [DATA_W-1:0]    rdata_q;

  // Read tags: tag_v[k]/tag_id[k] is a read issued k+1 cycles ago.
  logic [RD_LAT-1:0]    tag_v;
  logic [ID_W-1:0]      tag_id [RD_LAT];

  // First requester at or after rr_ptr, wrapping modulo NUM_CORES.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      idx = rr_ptr + ID_W'(i);
      if (!found && bus.core_req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign win_we       = bus.core_we[winner];
  assign bus.core_gnt = (found && !rst) ? (NUM_CORES'(1) << winner) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr        <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
      rvalid_q      <= '0;
      rdata_q       <= '0;
      tag_v         <= '0;
      for (int k = 0; k < RD_LAT; k++) tag_id[k] <= '0;
    end else begin
      mem_read_q  <= found & ~win_we;
      mem_write_q <= found & win_we;
      if (found) begin
        rr_ptr        <= winner + 1'b1;
        mem_address_q <= bus.core_addr[winner*ADDR_W +: ADDR_W];
        mem_data_in_q <= bus.core_wdata[winner*DATA_W +: DATA_W];
      end
      tag_v[0]  <= found & ~win_we;
      tag_id[0] <= winner;
      for (int k = 1; k < RD_LAT; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
      // Memory data is sampled in the same edge the tag leaves the pipeline.
      rvalid_q <= tag_v[RD_LAT-1] ? (NUM_CORES'(1) << tag_id[RD_LAT-1]) : '0;
      if (tag_v[RD_LAT-1]) rdata_q <= bus.mem_data_out;
    end
  end

  assign bus.mem_read    = mem_read_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_data_in = mem_data_in_q;
  assign bus.core_rvalid = rvalid_q;
  assign bus.core_rdata  = rdata_q;
  assign dbg_rr_ptr      = rr_ptr;

`ifdef MEM_ARB_STATS_EN
  logic [15:0] grant_cnt [NUM_CORES];
  logic [15:0] conflict_cnt;
  logic        multi_req;

  // Two or more set bits means at least one requester lost this cycle.
  assign multi_req = (bus.core_req & (bus.core_req - 1'b1)) != '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CORES; c++) grant_cnt[c] <= '0;
      conflict_cnt <= '0;
    end else begin
      if (found && grant_cnt[winner] != 16'hFFFF) grant_cnt[winner] <= grant_cnt[winner] + 16'd1;
      if (multi_req && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

  assign stat_count    = grant_cnt[stat_sel];
  assign stat_conflict = conflict_cnt;
`endif
endmodule
